// File: rtl/data_mem_access_ctrl.sv
// data_mem_access_ctrl: MEM-stage initiator for the word-addressed data memory.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   memReadEn/memWriteEn pipeline load/store request (store wins if both set)
//   addr, storeData      byte address and store value from the pipeline
//   loadData             last completed load value
//   done                 one-cycle pulse when an access finishes
//   freeze               stall request to the pipeline (combinational)
//   addrError            one-cycle pulse for an out-of-range/misaligned request
//   memAdr, writeData    latched address/data driven to the memory
//   memRead, memWrite    registered memory enables, held MEM_LATENCY cycles
//   readData             combinational memory read data
module data_mem_access_ctrl #(
    parameter int          MEM_LATENCY = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WORD_COUNT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memReadEn,
    input  logic        memWriteEn,
    input  logic [31:0] addr,
    input  logic [31:0] storeData,
    output logic [31:0] loadData,
    output logic        done,
    output logic        freeze,
    output logic        addrError,
    output logic [31:0] memAdr,
    output logic [31:0] writeData,
    output logic        memRead,
    output logic        memWrite,
    input  logic [31:0] readData
);
    localparam int CW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] count;
    logic          is_write;
    logic          req, ok, accept, last, op_write;
    logic [32:0]   addr_x;

    // 33-bit compare so the upper bound cannot wrap
    assign req    = memReadEn | memWriteEn;
    assign addr_x = {1'b0, addr};
    assign ok     = addr_x >= {1'b0, BASE_ADDR} &&
                    addr_x < {1'b0, BASE_ADDR} + 33'(4 * WORD_COUNT) &&
                    addr[1:0] == 2'b00;
    assign accept = state == IDLE && req && ok;
    assign last   = state == ACCESS && count == '0;
    // op type of the access that will be in flight next cycle
    assign op_write = accept ? memWriteEn : is_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        freeze  = 1'b0;
        state_n = accept ? ACCESS : last ? DONE : state == DONE ? IDLE : state;
        freeze  = accept || state == ACCESS;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            is_write  <= 1'b0;
            memAdr    <= '0;
            writeData <= '0;
            loadData  <= '0;
            done      <= 1'b0;
            addrError <= 1'b0;
            memRead   <= 1'b0;
            memWrite  <= 1'b0;
        end else begin
            done      <= state_n == DONE;
            addrError <= state == IDLE && req && !ok;
            memRead   <= state_n == ACCESS && !op_write;
            memWrite  <= state_n == ACCESS && op_write;
            if (accept) begin
                memAdr    <= addr;
                writeData <= storeData;
                is_write  <= memWriteEn;
                count     <= CW'(MEM_LATENCY - 1);
            end else if (state == ACCESS && count != '0) begin
                count <= count - 1'b1;
            end
            if (last && !is_write) loadData <= readData;
        end
    end
endmodule
